// File: rtl/pipe_sink_buffer.sv
// Pipeline sink FIFO: accepts words from an upstream valid/allow stage and returns them on request.
// Optional SINK_CHECKSUM_EN adds a running XOR checksum output of all accepted words.
module pipe_sink_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       validin,
  input  logic [WIDTH-1:0]           datain,
  output logic                       allowin,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow
`ifdef SINK_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]           checksum
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             underflow_q;
  logic             push, pop;

  // allowin depends only on registered occupancy, never on this cycle's inputs
  assign allowin = (count_q != Full);
  assign push    = validin & allowin;
  assign pop     = rd_req & (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (rd_req && (count_q == '0)) underflow_q <= 1'b1;
    end
  end

  // Storage and read data carry no reset
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= datain;
    if (pop && !rst)  rd_data_q <= mem[rd_ptr_q];
  end

`ifdef SINK_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else if (push) begin
      checksum_q <= checksum_q ^ datain;
    end
  end

  assign checksum = checksum_q;
`endif

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign count     = count_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pipe_sink_buffer.sv
// Scoreboard bench for pipe_sink_buffer: reads push expectations into a queue, a monitor checks them.
// Optional SINK_CHECKSUM_EN also checks the checksum output.
module tb_pipe_sink_buffer;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             validin;
  logic [WIDTH-1:0] datain;
  logic             allowin;
  logic             rd_req;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic [2:0]       count;
  logic             underflow;
`ifdef SINK_CHECKSUM_EN
  logic [WIDTH-1:0] checksum;
`endif

  typedef struct {
    logic [WIDTH-1:0] data;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [WIDTH-1:0] csum;

  pipe_sink_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .validin   (validin),
    .datain    (datain),
    .allowin   (allowin),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .underflow (underflow)
`ifdef SINK_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expect the word popped by the coming edge to appear one cycle later
  task automatic exp_rd(input logic [WIDTH-1:0] d);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    rd_req = 1'b1;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rd_data", rd_data, e.data);
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check("rd_valid_missing", {31'd0, rd_valid}, 32'd1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; validin = 1'b0; datain = '0; rd_req = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_count", {29'd0, count}, 32'd0);
    check("reset_allowin", {31'd0, allowin}, 32'd1);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset_underflow", {31'd0, underflow}, 32'd0);

    // Basic in-order push then read
    validin = 1'b1;
    datain = 32'h11; step();
    datain = 32'h22; step();
    datain = 32'h33; step();
    validin = 1'b0;
    check("fill3_count", {29'd0, count}, 32'd3);
    exp_rd(32'h11); step();
    exp_rd(32'h22); step();
    exp_rd(32'h33); step();
    rd_req = 1'b0; step();
    check("drain3_count", {29'd0, count}, 32'd0);

    // Fill to full with validin held; word 5 must wait upstream
    validin = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      datain = WIDTH'(w);
      step();
    end
    check("full_count", {29'd0, count}, 32'd4);
    check("full_allowin", {31'd0, allowin}, 32'd0);
    datain = 32'd5; step(); step();
    check("full_hold_count", {29'd0, count}, 32'd4);
    check("full_hold_allowin", {31'd0, allowin}, 32'd0);

    // Full with validin and rd_req together: pop only
    exp_rd(32'd1); step();
    rd_req = 1'b0;
    check("full_pop_count", {29'd0, count}, 32'd3);
    check("full_pop_allowin", {31'd0, allowin}, 32'd1);
    step();
    validin = 1'b0;
    check("refill_count", {29'd0, count}, 32'd4);
    for (int w = 2; w <= 5; w++) begin
      exp_rd(WIDTH'(w));
      step();
    end
    rd_req = 1'b0; step();
    check("drain4_count", {29'd0, count}, 32'd0);
    check("no_underflow_yet", {31'd0, underflow}, 32'd0);

    // Empty with push and read together: no bypass, underflow
    validin = 1'b1; datain = 32'hAA; rd_req = 1'b1; step();
    validin = 1'b0; rd_req = 1'b0;
    check("empty_rw_count", {29'd0, count}, 32'd1);
    check("empty_rw_underflow", {31'd0, underflow}, 32'd1);
    check("empty_rw_rd_valid", {31'd0, rd_valid}, 32'd0);
    exp_rd(32'hAA); step();
    rd_req = 1'b0; step();
    check("aa_drain_count", {29'd0, count}, 32'd0);
    check("underflow_sticky", {31'd0, underflow}, 32'd1);

    // Reset with occupancy 3 and a push pending
    validin = 1'b1;
    datain = 32'h31; step();
    datain = 32'h32; step();
    datain = 32'h33; step();
    check("pre_rst_count", {29'd0, count}, 32'd3);
    datain = 32'h77; rst = 1'b1; step();
    rst = 1'b0; validin = 1'b0;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_underflow", {31'd0, underflow}, 32'd0);
    check("rst_allowin", {31'd0, allowin}, 32'd1);
`ifdef SINK_CHECKSUM_EN
    check("rst_checksum", checksum, 32'd0);
`endif
    step();
    check("rst_no_store", {29'd0, count}, 32'd0);

    // Interleaved traffic at occupancy 2, wrapping pointers
    csum = '0;
    validin = 1'b1;
    for (int i = 0; i < 2; i++) begin
      datain = 32'h100 + 32'(i);
      csum ^= datain;
      step();
    end
    for (int i = 2; i < 10; i++) begin
      datain = 32'h100 + 32'(i);
      csum ^= datain;
      exp_rd(32'h100 + 32'(i - 2));
      step();
    end
    validin = 1'b0; rd_req = 1'b0;
    check("interleave_count", {29'd0, count}, 32'd2);
`ifdef SINK_CHECKSUM_EN
    check("checksum", checksum, csum);
`endif
    exp_rd(32'h108); step();
    exp_rd(32'h109); step();
    rd_req = 1'b0; step();
    check("final_count", {29'd0, count}, 32'd0);

    step(); step();
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
